// File: rtl/flash_ctrl_pkg.sv
// rtl/flash_ctrl_pkg.sv - state encodings, read-array command and address range for flash_ctrl
package flash_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_CMD_REC = 3'd2,
    ST_READ    = 3'd3,
    ST_DONE    = 3'd4,
    ST_RELEASE = 3'd5
  } flash_state_e;

  localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

  // Word address pins are numbered [22:1]; bit 0 does not exist in word mode.
  localparam int FLASH_ADDR_HI = 22;
  localparam int FLASH_ADDR_LO = 1;

endpackage

// File: rtl/flash_data_tri.sv
// rtl/flash_data_tri.sv - 16-bit tristate buffer for the shared flash data bus
module flash_data_tri (
  input  logic        drive,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  inout  wire  [15:0] pad
);

  assign pad     = drive ? wr_data : 16'hzzzz;
  assign rd_data = pad;

endmodule

// File: rtl/flash_ctrl.sv
// rtl/flash_ctrl.sv - single-word parallel NOR flash reader; FLASH_READ_ARRAY_CMD_EN adds a read-array command before each read
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int READ_CYCLES = 4,
  parameter int WE_CYCLES   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             need_to_work,
  input  logic [FLASH_ADDR_HI:FLASH_ADDR_LO] addr_in,
  output logic                             work_done,
  output logic [15:0]                      data_out,
  output logic                             busy,
  output logic [FLASH_ADDR_HI:FLASH_ADDR_LO] flash_addr,
  inout  wire  [15:0]                      flash_data,
  output logic                             flash_ce_n,
  output logic                             flash_oe_n,
  output logic                             flash_we_n,
  output logic                             flash_byte_n,
  output logic                             flash_vpen,
  output logic                             flash_rp_n
);

  // The 4-bit cycle counter cannot represent longer phases without wrapping.
  if (READ_CYCLES < 1 || READ_CYCLES > 15 || WE_CYCLES < 1 || WE_CYCLES > 15) begin : g_bad_cycles
    $error("flash_ctrl: READ_CYCLES and WE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] READ_LAST = 4'(READ_CYCLES - 1);
`ifdef FLASH_READ_ARRAY_CMD_EN
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
`endif

  flash_state_e state, state_next;
  logic [3:0]   cnt;
  logic         bus_drive;
  logic [15:0]  bus_rd;

  flash_data_tri u_data_tri (
    .drive   (bus_drive),
    .wr_data (FLASH_CMD_READ_ARRAY),
    .rd_data (bus_rd),
    .pad     (flash_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      flash_addr <= '0;
      data_out   <= 16'd0;
    end else begin
      state <= state_next;
      // Restart on every state entry; saturate instead of wrapping.
      if (state_next != state) begin
        cnt <= 4'd0;
      end else if (cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
      if (state == ST_IDLE && need_to_work) begin
        flash_addr <= addr_in;
      end
      if (state == ST_READ && cnt == READ_LAST) begin
        data_out <= bus_rd;
      end
    end
  end

  always_comb begin
    state_next = state;
    flash_ce_n = 1'b1;
    flash_oe_n = 1'b1;
    flash_we_n = 1'b1;
    bus_drive  = 1'b0;
    work_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (need_to_work) begin
`ifdef FLASH_READ_ARRAY_CMD_EN
          state_next = ST_CMD;
`else
          state_next = ST_READ;
`endif
        end
      end
`ifdef FLASH_READ_ARRAY_CMD_EN
      ST_CMD: begin
        flash_ce_n = 1'b0;
        flash_we_n = 1'b0;
        bus_drive  = 1'b1;
        if (cnt == WE_LAST) begin
          state_next = ST_CMD_REC;
        end
      end
      // Hold data one cycle past the we_n rising edge for write hold time.
      ST_CMD_REC: begin
        bus_drive  = 1'b1;
        state_next = ST_READ;
      end
`endif
      ST_READ: begin
        flash_ce_n = 1'b0;
        flash_oe_n = 1'b0;
        if (cnt == READ_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        work_done  = 1'b1;
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!need_to_work) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy         = (state != ST_IDLE);
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b1;
  assign flash_rp_n   = 1'b1;

endmodule
